// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode constants, instruction field positions
// and the FSM state encoding used by the instruction decode buffer.
package decode_pkg;

  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_LDM  = 5'd12;
  localparam logic [4:0] OP_IADD = 5'd13;
  localparam logic [4:0] OP_SHL  = 5'd14;
  localparam logic [4:0] OP_SHR  = 5'd15;
  localparam logic [4:0] OP_CALL = 5'd20;
  localparam logic [4:0] OP_RET  = 5'd21;
  localparam logic [4:0] OP_RTI  = 5'd22;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 11;
  localparam int RDST_MSB = 10;
  localparam int RDST_LSB = 8;
  localparam int RSRC_MSB = 7;
  localparam int RSRC_LSB = 5;

  typedef logic [0:0] state_t;

  localparam state_t S_OP  = 1'b0;
  localparam state_t S_IMM = 1'b1;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode classifier: flags opcodes whose instruction is
// followed by a second word carrying an immediate operand.
module opcode_classifier
  import decode_pkg::*;
(
  input  logic [4:0] opcode,
  output logic       needs_imm
);

  // Only the immediate-form ALU/load opcodes consume a second word;
  // control-flow opcodes and everything else are single-word.
  always_comb begin
    needs_imm = 1'b0;
    case (opcode)
      OP_LDM, OP_IADD, OP_SHL, OP_SHR: needs_imm = 1'b1;
      OP_NOP, OP_CALL, OP_RET, OP_RTI: needs_imm = 1'b0;
      default:                         needs_imm = 1'b0;
    endcase
  end

endmodule

// File: rtl/instruction_decode_buffer.sv
// Instruction decode buffer: assembles one- or two-word instructions from
// the fetch stream and presents decoded fields one cycle after the final
// word is accepted. Honours stall (freeze) and flush (discard).
module instruction_decode_buffer
  import decode_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] instr_in,
  input  logic         instr_valid,
  input  logic         stall,
  input  logic         flush,
  output logic         dec_valid,
  output logic [4:0]   dec_opcode,
  output logic [2:0]   dec_rdst,
  output logic [2:0]   dec_rsrc,
  output logic [W-1:0] dec_imm,
  output logic         dec_has_imm,
  output logic         dec_busy,
  output logic [15:0]  issued_count
);

  state_t     state;
  logic [4:0] lat_opcode;
  logic [2:0] lat_rdst;
  logic [2:0] lat_rsrc;
  logic       needs_imm;

  logic [4:0] in_opcode;
  logic [2:0] in_rdst;
  logic [2:0] in_rsrc;

  assign in_opcode = instr_in[OPC_MSB:OPC_LSB];
  assign in_rdst   = instr_in[RDST_MSB:RDST_LSB];
  assign in_rsrc   = instr_in[RSRC_MSB:RSRC_LSB];

  opcode_classifier u_classifier (
    .opcode    (in_opcode),
    .needs_imm (needs_imm)
  );

  // Busy while the first word of an immediate instruction is held.
  assign dec_busy = (state == S_IMM);

  // Decode FSM and registered outputs; flush beats stall, stall beats idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_OP;
      lat_opcode   <= '0;
      lat_rdst     <= '0;
      lat_rsrc     <= '0;
      dec_valid    <= 1'b0;
      dec_opcode   <= '0;
      dec_rdst     <= '0;
      dec_rsrc     <= '0;
      dec_imm      <= '0;
      dec_has_imm  <= 1'b0;
      issued_count <= '0;
    end else if (flush) begin
      state       <= S_OP;
      lat_opcode  <= '0;
      lat_rdst    <= '0;
      lat_rsrc    <= '0;
      dec_valid   <= 1'b0;
      dec_opcode  <= '0;
      dec_rdst    <= '0;
      dec_rsrc    <= '0;
      dec_imm     <= '0;
      dec_has_imm <= 1'b0;
    end else if (stall) begin
      state <= state;
    end else if (!instr_valid) begin
      dec_valid   <= 1'b0;
      dec_opcode  <= '0;
      dec_rdst    <= '0;
      dec_rsrc    <= '0;
      dec_imm     <= '0;
      dec_has_imm <= 1'b0;
    end else if (state == S_IMM) begin
      state        <= S_OP;
      dec_valid    <= 1'b1;
      dec_opcode   <= lat_opcode;
      dec_rdst     <= lat_rdst;
      dec_rsrc     <= lat_rsrc;
      dec_imm      <= instr_in;
      dec_has_imm  <= 1'b1;
      issued_count <= issued_count + 16'd1;
    end else if (needs_imm) begin
      state       <= S_IMM;
      lat_opcode  <= in_opcode;
      lat_rdst    <= in_rdst;
      lat_rsrc    <= in_rsrc;
      dec_valid   <= 1'b0;
      dec_opcode  <= '0;
      dec_rdst    <= '0;
      dec_rsrc    <= '0;
      dec_imm     <= '0;
      dec_has_imm <= 1'b0;
    end else begin
      dec_valid    <= 1'b1;
      dec_opcode   <= in_opcode;
      dec_rdst     <= in_rdst;
      dec_rsrc     <= in_rsrc;
      dec_imm      <= '0;
      dec_has_imm  <= 1'b0;
      issued_count <= issued_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_instruction_decode_buffer.sv
// Directed self-checking bench for instruction_decode_buffer.
module tb_instruction_decode_buffer;

  logic        clk;
  logic        rst;
  logic [15:0] instr_in;
  logic        instr_valid;
  logic        stall;
  logic        flush;
  logic        dec_valid;
  logic [4:0]  dec_opcode;
  logic [2:0]  dec_rdst;
  logic [2:0]  dec_rsrc;
  logic [15:0] dec_imm;
  logic        dec_has_imm;
  logic        dec_busy;
  logic [15:0] issued_count;

  int compared;
  int mismatched;

  instruction_decode_buffer #(.W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_in     (instr_in),
    .instr_valid  (instr_valid),
    .stall        (stall),
    .flush        (flush),
    .dec_valid    (dec_valid),
    .dec_opcode   (dec_opcode),
    .dec_rdst     (dec_rdst),
    .dec_rsrc     (dec_rsrc),
    .dec_imm      (dec_imm),
    .dec_has_imm  (dec_has_imm),
    .dec_busy     (dec_busy),
    .issued_count (issued_count)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs and return #1 after the capturing edge.
  task automatic applyStimulus(input logic v, input logic [15:0] w, input logic s, input logic f);
    instr_valid = v;
    instr_in    = w;
    stall       = s;
    flush       = f;
    @(posedge clk);
    #1;
  endtask

  // Check the whole decoded bundle in one go.
  task automatic checkDecoded(input string tag, input logic v, input logic [4:0] op,
                              input logic [2:0] rd, input logic [2:0] rs,
                              input logic [15:0] imm, input logic hi,
                              input logic busy, input logic [15:0] cnt);
    checkOutput({tag, ".valid"}, 32'(dec_valid), 32'(v));
    checkOutput({tag, ".opcode"}, 32'(dec_opcode), 32'(op));
    checkOutput({tag, ".rdst"}, 32'(dec_rdst), 32'(rd));
    checkOutput({tag, ".rsrc"}, 32'(dec_rsrc), 32'(rs));
    checkOutput({tag, ".imm"}, 32'(dec_imm), 32'(imm));
    checkOutput({tag, ".has_imm"}, 32'(dec_has_imm), 32'(hi));
    checkOutput({tag, ".busy"}, 32'(dec_busy), 32'(busy));
    checkOutput({tag, ".count"}, 32'(issued_count), 32'(cnt));
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    rst         = 1'b0;
    instr_in    = '0;
    instr_valid = 1'b0;
    stall       = 1'b0;
    flush       = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkDecoded("reset", 1'b0, 5'd0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b0, 16'd0);
    #2 rst = 1'b1;

    applyStimulus(1'b0, 16'h1AA0, 1'b0, 1'b0);
    checkDecoded("post_reset_idle", 1'b0, 5'd0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b0, 16'd0);

    // Single-word instruction.
    applyStimulus(1'b1, 16'h1AA0, 1'b0, 1'b0);
    checkDecoded("single", 1'b1, 5'd3, 3'd2, 3'd5, 16'h0, 1'b0, 1'b0, 16'd1);

    // Two-word LDM back to back.
    applyStimulus(1'b1, 16'h6100, 1'b0, 1'b0);
    checkDecoded("ldm_bubble", 1'b0, 5'd0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b1, 16'd1);
    applyStimulus(1'b1, 16'h00FF, 1'b0, 1'b0);
    checkDecoded("ldm_issue", 1'b1, 5'd12, 3'd1, 3'd0, 16'h00FF, 1'b1, 1'b0, 16'd2);

    // Stall freezes a valid output.
    applyStimulus(1'b1, 16'h1AA0, 1'b0, 1'b0);
    checkDecoded("pre_stall", 1'b1, 5'd3, 3'd2, 3'd5, 16'h0, 1'b0, 1'b0, 16'd3);
    applyStimulus(1'b1, 16'h0000, 1'b1, 1'b0);
    checkDecoded("stall_hold_valid", 1'b1, 5'd3, 3'd2, 3'd5, 16'h0, 1'b0, 1'b0, 16'd3);

    // Stall while waiting for the immediate.
    applyStimulus(1'b1, 16'h6100, 1'b0, 1'b0);
    checkDecoded("stall_ldm_bubble", 1'b0, 5'd0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b1, 16'd3);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 16'h1AA0, 1'b1, 1'b0);
      checkDecoded("stall_frozen", 1'b0, 5'd0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b1, 16'd3);
    end
    applyStimulus(1'b1, 16'h0042, 1'b0, 1'b0);
    checkDecoded("stall_ldm_issue", 1'b1, 5'd12, 3'd1, 3'd0, 16'h0042, 1'b1, 1'b0, 16'd4);

    // Flush drops a half-assembled instruction, overriding stall.
    applyStimulus(1'b1, 16'h6100, 1'b0, 1'b0);
    checkOutput("flush_pre.busy", 32'(dec_busy), 32'd1);
    applyStimulus(1'b1, 16'h00FF, 1'b1, 1'b1);
    checkDecoded("flush", 1'b0, 5'd0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b0, 16'd4);
    applyStimulus(1'b1, 16'h1AA0, 1'b0, 1'b0);
    checkDecoded("after_flush", 1'b1, 5'd3, 3'd2, 3'd5, 16'h0, 1'b0, 1'b0, 16'd5);

    // Idle cycle in S_IMM keeps waiting; idle zeroes the outputs.
    applyStimulus(1'b1, 16'h6900, 1'b0, 1'b0);
    checkOutput("iadd_bubble.busy", 32'(dec_busy), 32'd1);
    applyStimulus(1'b0, 16'hFFFF, 1'b0, 1'b0);
    checkDecoded("imm_wait_idle", 1'b0, 5'd0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b1, 16'd5);
    applyStimulus(1'b1, 16'h0033, 1'b0, 1'b0);
    checkDecoded("iadd_issue", 1'b1, 5'd13, 3'd1, 3'd0, 16'h0033, 1'b1, 1'b0, 16'd6);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    checkDecoded("idle_zero", 1'b0, 5'd0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b0, 16'd6);

    // Asynchronous reset in the middle of S_IMM.
    applyStimulus(1'b1, 16'h6100, 1'b0, 1'b0);
    checkOutput("rst_mid.busy_before", 32'(dec_busy), 32'd1);
    instr_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    checkDecoded("rst_mid", 1'b0, 5'd0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b0, 16'd0);
    #2 rst = 1'b1;
    applyStimulus(1'b1, 16'h00FF, 1'b0, 1'b0);
    checkDecoded("rst_mid_after", 1'b1, 5'd0, 3'd0, 3'd7, 16'h0, 1'b0, 1'b0, 16'd1);

    // Counter wrap: fresh reset, 65535 NOPs, then one more.
    instr_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    instr_valid = 1'b1;
    instr_in    = 16'h0000;
    stall       = 1'b0;
    flush       = 1'b0;
    repeat (65535) @(posedge clk);
    #1;
    checkDecoded("nop_ffff", 1'b1, 5'd0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b0, 16'hFFFF);
    applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0);
    checkDecoded("nop_wrap", 1'b1, 5'd0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/instruction_decode_buffer.md
INSTRUCTION_DECODE_BUFFER -- requirements
Module: instruction_decode_buffer

Interface
REQ-001 SHALL have parameter W, default 16, instruction/immediate word width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port instr_in  input  W  fetched word from instruction memory (opcode word or immediate word).
REQ-005 SHALL have port instr_valid  input  1  instr_in carries a real fetched word this cycle.
REQ-006 SHALL have port stall  input  1  downstream hazard; hold all state and outputs.
REQ-007 SHALL have port flush  input  1  taken jump/call/ret; discard in-flight words.
REQ-008 SHALL have port dec_valid  output  1  decoded instruction presented this cycle.
REQ-009 SHALL have ports dec_opcode (5), dec_rdst (3), dec_rsrc (3)  output  decoded fields instr[15:11], [10:8], [7:5].
REQ-010 SHALL have port dec_imm  output  W  immediate operand; zero when dec_has_imm=0.
REQ-011 SHALL have port dec_has_imm  output  1  dec_imm is meaningful.
REQ-012 SHALL have port dec_busy  output  1  high while in S_IMM (waiting for immediate word).
REQ-013 SHALL have port issued_count  output  16  count of instructions issued with dec_valid=1.

Function
REQ-014 SHALL implement FSM states S_OP (expect opcode word) and S_IMM (expect immediate word).
REQ-015 Accept condition: instr_valid=1, stall=0, flush=0.
REQ-016 In S_OP on accept with opcode in IMM set {12 LDM, 13 IADD, 14 SHL, 15 SHR}: latch fields, go S_IMM, drive bubble (dec_valid=0) next cycle.
REQ-017 In S_OP on accept with any other opcode: register fields, dec_valid=1, dec_has_imm=0, dec_imm=0 one cycle later.
REQ-018 In S_IMM on accept: dec_imm<=instr_in, dec_has_imm=1, dec_valid=1 with latched fields, return S_OP; opcode decode of this word SHALL NOT occur.
REQ-019 Latency: one cycle from accept of final word to dec_valid.
REQ-020 Word 0x0000 SHALL issue as valid NOP (opcode 0) and increment issued_count.
REQ-021 stall=1, flush=0: state, outputs, latched fields, issued_count SHALL hold; instr_in ignored.
REQ-022 flush=1 SHALL override stall and instr_valid: next cycle dec_valid=0, all fields/imm zero, state S_OP; incoming word discarded, a half-assembled immediate instruction dropped.
REQ-023 instr_valid=0, stall=0, flush=0: dec_valid=0, fields zero, FSM state and latched fields held (S_IMM keeps waiting).
REQ-024 issued_count SHALL increment by 1 on each cycle dec_valid transitions into 1 from an accept, wrap 0xFFFF->0x0000.
REQ-025 dec_busy SHALL be combinational from state (1 iff S_IMM).

Reset
REQ-026 On rst=0 asynchronously: state S_OP, dec_valid=0, dec_opcode/rdst/rsrc=0, dec_imm=0, dec_has_imm=0, issued_count=0, latched fields=0.
REQ-027 Reset asserted mid S_IMM SHALL drop the pending instruction; first word after release decoded as opcode word.
REQ-028 Outputs SHALL stay at reset values until the first accept after rst rises.

Structure
REQ-029 Shared package decode_pkg SHALL hold opcode constants (OP_NOP=0, OP_LDM=12, OP_IADD=13, OP_SHL=14, OP_SHR=15, CALL=20, RET=21, RTI=22), field bit positions, FSM state typedef.
REQ-030 One sub-module opcode_classifier (combinational: opcode -> needs_imm) SHALL be instantiated; no other hierarchy.

Verification
REQ-031 Reset, then instr_in=0x1AA0 accepted -> next cycle dec_valid=1, opcode=3, rdst=2, rsrc=5, has_imm=0, issued_count=1.
REQ-032 0x6100 then 0x00FF on consecutive accepts -> bubble cycle, then dec_valid=1, opcode=12, rdst=1, dec_imm=0x00FF, has_imm=1, dec_busy high exactly one cycle.
REQ-033 0x6100 accepted, stall=1 for 3 cycles, then 0x0042 -> outputs frozen 3 cycles, then opcode=12, dec_imm=0x0042.
REQ-034 0x6100 accepted, then flush=1 with instr_valid=1, instr_in=0x00FF -> dec_valid=0, state S_OP; next 0x1AA0 decodes as opcode 3.
REQ-035 Preload issued_count to 0xFFFF via 65535 NOPs, issue one more -> issued_count=0x0000.
REQ-036 rst=0 mid S_IMM between clock edges -> outputs zero immediately; after release 0x00FF decodes as opcode 0, rdst=0, rsrc=7.
